// File: rtl/plot_pkg.sv
// plot_pkg: shared constants and the FSM state type for node_plot_streamer.
//   FRAC_BITS : fractional bits of the Q20.12 node position format
//   SCREEN_W  : visible width in pixels (x valid 0..SCREEN_W-1)
//   SCREEN_H  : visible height in pixels (y valid 0..SCREEN_H-1)
//   state_t   : 2-bit scan state {IDLE, EVAL, WAIT, DONE}
package plot_pkg;

    localparam int FRAC_BITS = 12;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fixed_to_pixel.sv
// fixed_to_pixel: combinational conversion of one signed Q20.12 node position
// to integer screen coordinates plus an on-screen flag.
//   x, y    : signed fixed-point position (32 bits each)
//   px, py  : low bits of the integer pixel coordinates
//   visible : 1 when both coordinates are non-negative and inside the screen
// Build option: define PLOT_ROUND_EN to round to nearest (half up) instead of
// truncating toward -inf.
module fixed_to_pixel
    import plot_pkg::*;
#(
    parameter int FRAC_BITS_P = plot_pkg::FRAC_BITS,
    parameter int SCREEN_W_P  = plot_pkg::SCREEN_W,
    parameter int SCREEN_H_P  = plot_pkg::SCREEN_H,
    parameter int PIX_X_W     = 10,
    parameter int PIX_Y_W     = 9
) (
    input  logic [31:0]        x,
    input  logic [31:0]        y,
    output logic [PIX_X_W-1:0] px,
    output logic [PIX_Y_W-1:0] py,
    output logic               visible
);

`ifdef PLOT_ROUND_EN
    // One extra bit so adding the half-LSB to 0x7FFFFFFF cannot wrap negative.
    localparam int FW = 33;
`else
    localparam int FW = 32;
`endif

    localparam logic signed [FW-1:0] X_LIM = FW'(SCREEN_W_P);
    localparam logic signed [FW-1:0] Y_LIM = FW'(SCREEN_H_P);

    logic signed [FW-1:0] x_full;
    logic signed [FW-1:0] y_full;

`ifdef PLOT_ROUND_EN
    localparam logic signed [FW-1:0] HALF = FW'(1) <<< (FRAC_BITS_P - 1);
    assign x_full = ($signed({x[31], x}) + HALF) >>> FRAC_BITS_P;
    assign y_full = ($signed({y[31], y}) + HALF) >>> FRAC_BITS_P;
`else
    assign x_full = $signed(x) >>> FRAC_BITS_P;
    assign y_full = $signed(y) >>> FRAC_BITS_P;
`endif

    // Sign is taken from the original value, so negatives never wrap on screen.
    assign visible = !x[31] && !y[31] && (x_full < X_LIM) && (y_full < Y_LIM);
    assign px      = x_full[PIX_X_W-1:0];
    assign py      = y_full[PIX_Y_W-1:0];

endmodule

// File: rtl/node_plot_streamer.sv
// node_plot_streamer: on frame_start, snapshots all node positions, converts
// each to screen coordinates, clips off-screen nodes and streams visible ones
// one at a time over a valid/ready interface.
//   clk, reset      : clock (rising edge), synchronous active-low reset
//   frame_start     : one-cycle pulse, positions settled for this frame
//   x_pos_flat      : node i x at [32i+31:32i], signed Q20.12
//   y_pos_flat      : node i y, same format
//   out_valid/ready : pixel word handshake (transfer on valid && ready)
//   out_x, out_y    : pixel column / row (row 0 at top)
//   out_node        : index of the emitted node
//   busy            : high whenever the scan is not IDLE
//   frame_done      : one-cycle pulse at the end of the frame scan
//   drop_count      : nodes clipped in the last/current frame, saturating
//   overrun         : sticky, frame_start seen while busy
// Build option: PLOT_ROUND_EN selects rounding in fixed_to_pixel.
module node_plot_streamer
    import plot_pkg::*;
#(
    parameter int NUM_NODES = 8,
    parameter int FRAC_BITS = plot_pkg::FRAC_BITS,
    parameter int SCREEN_W  = plot_pkg::SCREEN_W,
    parameter int SCREEN_H  = plot_pkg::SCREEN_H,
    parameter int PIX_X_W   = 10,
    parameter int PIX_Y_W   = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic [32*NUM_NODES-1:0]      x_pos_flat,
    input  logic [32*NUM_NODES-1:0]      y_pos_flat,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PIX_X_W-1:0]           out_x,
    output logic [PIX_Y_W-1:0]           out_y,
    output logic [$clog2(NUM_NODES)-1:0] out_node,
    output logic                         busy,
    output logic                         frame_done,
    output logic [7:0]                   drop_count,
    output logic                         overrun
);

    localparam int IDX_W = $clog2(NUM_NODES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [31:0]      snap_x [NUM_NODES];
    logic [31:0]      snap_y [NUM_NODES];

    logic [PIX_X_W-1:0] cur_px;
    logic [PIX_Y_W-1:0] cur_py;
    logic               cur_vis;
    logic               last_node;

    fixed_to_pixel #(
        .FRAC_BITS_P (FRAC_BITS),
        .SCREEN_W_P  (SCREEN_W),
        .SCREEN_H_P  (SCREEN_H),
        .PIX_X_W     (PIX_X_W),
        .PIX_Y_W     (PIX_Y_W)
    ) u_conv (
        .x       (snap_x[idx]),
        .y       (snap_y[idx]),
        .px      (cur_px),
        .py      (cur_py),
        .visible (cur_vis)
    );

    assign last_node  = (idx == LAST_IDX);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    // Snapshot storage needs no reset: it is always written before EVAL reads it.
    always_ff @(posedge clk) begin
        if (state == IDLE && reset && frame_start) begin
            for (int unsigned i = 0; i < NUM_NODES; i++) begin
                snap_x[i] <= x_pos_flat[32*i +: 32];
                snap_y[i] <= y_pos_flat[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_node   <= '0;
            drop_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (frame_start && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        idx        <= '0;
                        drop_count <= '0;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    if (cur_vis) begin
                        out_x     <= cur_px;
                        out_y     <= cur_py;
                        out_node  <= idx;
                        out_valid <= 1'b1;
                        state     <= WAIT;
                    end else begin
                        if (drop_count != 8'hFF) begin
                            drop_count <= drop_count + 8'd1;
                        end
                        if (last_node) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_node) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= EVAL;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_node_plot_streamer.sv
// tb_node_plot_streamer: table-driven and randomized checks of
// node_plot_streamer against an arithmetic reference model.
module tb_node_plot_streamer;

    localparam int N  = 8;
    localparam int FB = 12;
    localparam int SW = 640;
    localparam int SH = 480;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              frame_start = 1'b0;
    logic [32*N-1:0]   x_pos_flat = '0;
    logic [32*N-1:0]   y_pos_flat = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [9:0]        out_x;
    logic [8:0]        out_y;
    logic [2:0]        out_node;
    logic              busy;
    logic              frame_done;
    logic [7:0]        drop_count;
    logic              overrun;

    node_plot_streamer #(
        .NUM_NODES (N),
        .FRAC_BITS (FB),
        .SCREEN_W  (SW),
        .SCREEN_H  (SH),
        .PIX_X_W   (10),
        .PIX_Y_W   (9)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .x_pos_flat (x_pos_flat),
        .y_pos_flat (y_pos_flat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_node   (out_node),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_count (drop_count),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int node;
    } word_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        bit          vis;
        int          ex;
        int          ey;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    word_t       exp_q[$];
    word_t       got_q[$];
    logic [31:0] fx [N];
    logic [31:0] fy [N];
    int          exp_drop;
    logic        exp_overrun = 1'b0;
    int          done_cnt = 0;
    vec_t        tbl [N];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int x, input int y, input int n);
        return 32'((x * 1024 + y) * 16 + n);
    endfunction

    // Monitor: records transfers, counts frame_done pulses, checks hold-stability.
    logic        pend = 1'b0;
    logic [21:0] held = '0;
    always @(posedge clk) begin
        if (reset) begin
            if (pend)
                check("hold_stable", {out_valid, out_x, out_y, out_node}, {1'b1, held});
            if (out_valid && out_ready)
                got_q.push_back('{int'(out_x), int'(out_y), int'(out_node)});
            if (frame_done)
                done_cnt++;
            pend = out_valid && !out_ready;
            held = {out_x, out_y, out_node};
        end else begin
            pend = 1'b0;
        end
    end

    // Reference: pixel = floor(value / 2^FB) (or nearest, half up), visible if
    // the original value is non-negative and the pixel lies on screen.
    function automatic void model_pix(input logic [31:0] v, input int lim,
                                      output bit vis, output int p);
        longint s;
        vis = 1'b0;
        p   = 0;
        if (!v[31]) begin
            s = longint'(v);
`ifdef PLOT_ROUND_EN
            s = (s + 2048) / 4096;
`else
            s = s / 4096;
`endif
            vis = (s < lim);
            p   = int'(s);
        end
    endfunction

    task automatic build_model();
        bit vx, vy;
        int px, py;
        exp_q.delete();
        exp_drop = 0;
        for (int i = 0; i < N; i++) begin
            model_pix(fx[i], SW, vx, px);
            model_pix(fy[i], SH, vy, py);
            if (vx && vy) exp_q.push_back('{px, py, i});
            else          exp_drop++;
        end
    endtask

    task automatic load_all_visible();
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            fx[i] = 32'h000C8000;
            fy[i] = 32'((10 * (i + 1)) << 12);
            exp_q.push_back('{200, 10 * (i + 1), i});
        end
        exp_drop = 0;
    endtask

    task automatic load_table();
        exp_q.delete();
        exp_drop = 0;
        for (int i = 0; i < N; i++) begin
            fx[i] = tbl[i].x;
            fy[i] = tbl[i].y;
            if (tbl[i].vis) exp_q.push_back('{tbl[i].ex, tbl[i].ey, i});
            else            exp_drop++;
        end
    endtask

    function automatic logic [31:0] rnd_coord(input int lim);
        case ($urandom_range(0, 4))
            0:       return $urandom | 32'h8000_0000;
            1:       return $urandom;
            2:       return 32'(((lim - 1) << 12) + $urandom_range(0, 8191));
            default: return 32'(($urandom_range(0, lim + 40) << 12) | $urandom_range(0, 4095));
        endcase
    endfunction

    // mode 0: ready high; 1: random ready; 2: ready low 5 cycles after first
    // valid; 3: ready high plus a second frame_start mid-scan.
    task automatic run_frame(input string tag, input int mode, input bit chk_lat);
        bit finished = 1'b0;
        bit seen = 1'b0;
        int hold = 0;
        int n;
        got_q.delete();
        done_cnt = 0;
        for (int i = 0; i < N; i++) begin
            x_pos_flat[32*i +: 32] = fx[i];
            y_pos_flat[32*i +: 32] = fy[i];
        end
        out_ready   = 1'b1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        // Buses change after capture; the scan must use the snapshot.
        for (int i = 0; i < N; i++) begin
            x_pos_flat[32*i +: 32] = $urandom;
            y_pos_flat[32*i +: 32] = $urandom;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (chk_lat && cyc == 0) check({tag, "_lat_eval"}, out_valid, 0);
            if (chk_lat && cyc == 1) check({tag, "_lat_valid"}, out_valid, 1);
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (!seen && out_valid) begin
                        seen = 1'b1;
                        out_ready = 1'b0;
                        hold = 5;
                    end else if (hold > 0) begin
                        hold--;
                        if (hold == 0) out_ready = 1'b1;
                    end
                end
                3: frame_start = (cyc == 2);
                default: ;
            endcase
            @(posedge clk); #1;
        end
        frame_start = 1'b0;
        out_ready   = 1'b1;
        check({tag, "_finished"}, finished, 1);
        check({tag, "_word_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_word%0d", tag, i),
                  enc(got_q[i].x, got_q[i].y, got_q[i].node),
                  enc(exp_q[i].x, exp_q[i].y, exp_q[i].node));
        check({tag, "_drop_count"}, drop_count, exp_drop);
        check({tag, "_frame_done_cnt"}, done_cnt, 1);
        check({tag, "_overrun"}, overrun, exp_overrun);
    endtask

    initial begin
        bit seen;

        // Boundary vectors: {x, y, visible, expected px, expected py}.
        tbl[0] = '{32'hFFFFF000, 32'h00010000, 1'b0, 0, 0};
        tbl[1] = '{32'h00280000, 32'h00010000, 1'b0, 0, 0};
`ifdef PLOT_ROUND_EN
        tbl[2] = '{32'h0027FFFF, 32'h00010000, 1'b0, 0, 0};
        tbl[3] = '{32'h000C8800, 32'h0001E000, 1'b1, 201, 30};
`else
        tbl[2] = '{32'h0027FFFF, 32'h00010000, 1'b1, 639, 16};
        tbl[3] = '{32'h000C8800, 32'h0001E000, 1'b1, 200, 30};
`endif
        tbl[4] = '{32'h000C87FF, 32'h00000000, 1'b1, 200, 0};
        tbl[5] = '{32'h00000000, 32'h001DF000, 1'b1, 0, 479};
        tbl[6] = '{32'h00064000, 32'h001E0000, 1'b0, 0, 0};
        tbl[7] = '{32'h7FFFFFFF, 32'h00000000, 1'b0, 0, 0};

        // Reset state.
        reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_out_pix", {out_x, out_y, out_node}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        load_all_visible();
        run_frame("allvis", 0, 1'b1);

        load_table();
        run_frame("table", 0, 1'b0);

        load_all_visible();
        run_frame("backpressure", 2, 1'b0);

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++) begin
                fx[i] = rnd_coord(SW);
                fy[i] = rnd_coord(SH);
            end
            build_model();
            run_frame($sformatf("rand%0d", f), (f % 4 == 3) ? 2 : 1, 1'b0);
        end

        exp_overrun = 1'b1;
        load_all_visible();
        run_frame("overrun", 3, 1'b0);

        for (int i = 0; i < N; i++) begin
            fx[i] = rnd_coord(SW);
            fy[i] = rnd_coord(SH);
        end
        build_model();
        run_frame("sticky", 1, 1'b0);

        // Reset while a word is waiting for ready.
        load_table();
        for (int i = 0; i < N; i++) begin
            x_pos_flat[32*i +: 32] = fx[i];
            y_pos_flat[32*i +: 32] = fy[i];
        end
        out_ready   = 1'b0;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("rstmid_reached_wait", seen, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_drop_count", drop_count, 0);
        check("rstmid_overrun", overrun, 0);
        reset = 1'b1;
        out_ready = 1'b1;
        exp_overrun = 1'b0;
        @(posedge clk); #1;
        load_all_visible();
        run_frame("after_rst", 0, 1'b1);

        // frame_start coinciding with reset: reset wins.
        reset = 1'b0;
        frame_start = 1'b1;
        @(posedge clk); #1;
        check("rst_vs_start_busy", busy, 0);
        reset = 1'b1;
        frame_start = 1'b0;
        @(posedge clk); #1;
        check("rst_vs_start_idle", {busy, out_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/node_plot_streamer.md
Name: node_plot_streamer

Overview:
- Downstream consumer of the per-node position outputs (x_pos/y_pos, Q20.12 fixed point) of the cloth/rope simulation.
- On each frame_start it snapshots all node positions and converts each to integer screen coordinates.
- Nodes outside the screen are clipped. Visible nodes are streamed one at a time over a valid/ready interface to the pixel/framebuffer writer.
- Decouples the Verlet/constraint update cadence from the display path.

Parameters:
- NUM_NODES, 8, number of simulated nodes on the flat position buses
- FRAC_BITS, 12, fractional bits of the node fixed-point format
- SCREEN_W, 640, visible width in pixels; valid x is 0..SCREEN_W-1
- SCREEN_H, 480, visible height in pixels; valid y is 0..SCREEN_H-1
- PIX_X_W, 10, out_x width
- PIX_Y_W, 9, out_y width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (reset==0 clears state on the next clk edge)
- frame_start  in  1  single-cycle pulse: positions are settled for this frame
- x_pos_flat  in  32*NUM_NODES  node i x at bits [32i+31:32i], signed Q20.12
- y_pos_flat  in  32*NUM_NODES  node i y, same format
- out_valid  out  1  pixel word valid
- out_ready  in  1  downstream accepts when out_valid&&out_ready
- out_x  out  PIX_X_W  pixel column
- out_y  out  PIX_Y_W  pixel row (row 0 at top, y grows downward)
- out_node  out  $clog2(NUM_NODES)  index of the emitted node
- busy  out  1  high while not IDLE
- frame_done  out  1  one-cycle pulse at end of frame scan
- drop_count  out  8  nodes clipped in the last/current frame, saturating at 255
- overrun  out  1  sticky: frame_start arrived while busy

Behaviour:
- Reset (reset==0 at edge): state=IDLE, idx=0, out_valid=0, out_x=0, out_y=0, out_node=0, frame_done=0, drop_count=0, overrun=0. This takes priority over everything, including mid-frame; a pending out_valid word is discarded.
- States: IDLE, EVAL, WAIT, DONE.
- IDLE:
  - frame_start=1 captures all x/y into the snapshot registers, sets idx=0, clears drop_count, goes to EVAL.
  - Inputs are not sampled again until the next accepted frame_start.
- EVAL (one cycle per node): convert snapshot[idx] in the fixed_to_pixel function.
  - px = x>>>FRAC_BITS (arithmetic); py likewise.
  - Visible iff x bit31==0, px<SCREEN_W, y bit31==0, and py<SCREEN_H.
  - Visible: register out_x=px[PIX_X_W-1:0], out_y=py[PIX_Y_W-1:0], out_node=idx; set out_valid=1; go to WAIT.
  - Clipped: drop_count+=1 (saturating); if idx==NUM_NODES-1 go to DONE, else idx+=1 and stay in EVAL.
- WAIT:
  - out_valid, out_x, out_y and out_node are held stable until out_ready=1.
  - On handshake: out_valid=0 at the next edge; last node goes to DONE, otherwise idx+=1 and go to EVAL.
- DONE: frame_done=1 for exactly one cycle, then IDLE. busy=0 in IDLE only.
- Latency: frame_start at edge t gives the first out_valid at edge t+2 (t+1 EVAL, registered at t+2). Each visible node costs ≥2 cycles; each clipped node costs 1.
- frame_start while busy (including in DONE) is ignored and sets overrun=1. overrun clears only on reset.
- frame_start on the same edge as reset==0: reset wins.
- Boundary values:
  - x=SCREEN_W<<FRAC_BITS is clipped; (SCREEN_W<<FRAC_BITS)-1 maps to SCREEN_W-1.
  - Negative values are always clipped; no wraparound.

Optional Feature:
- Macro PLOT_ROUND_EN.
  - Defined: px/py = (value + (1<<(FRAC_BITS-1))) >>> FRAC_BITS, computed in 33 bits so 0x7FFFFFFF does not wrap. The visibility test uses the rounded result plus the original sign bit.
  - Undefined: truncation toward −inf as above.

Decomposition:
- Package plot_pkg holds:
  - FRAC_BITS, SCREEN_W, SCREEN_H
  - state enum {IDLE, EVAL, WAIT, DONE}
  - the 2-bit state typedef
- One combinational sub-module, fixed_to_pixel: inputs 32-bit x and y; outputs px, py and visible. It contains the PLOT_ROUND_EN variant.
- Snapshot registers, FSM, handshake and counters stay in node_plot_streamer.

Test Plan:
- All 8 nodes visible:
  - Stimulus: x=0x000C8000, node i y=(10*(i+1))<<12, out_ready=1, frame_start.
  - Response: 8 words with out_x=200, out_y=10,20,…,80 and out_node=0..7 in order; frame_done once; drop_count=0.
- Clipping:
  - Stimulus: node0 x=0xFFFFF000, node1 x=0x00280000 (640.0), node2 x=0x0027FFFF; other nodes visible.
  - Response: nodes 0 and 1 are never emitted; node2 gives out_x=639; drop_count=2.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles after the first out_valid.
  - Response: out_valid, out_x, out_y and out_node are stable for all 5 cycles; exactly one transfer on the ready cycle; no duplicates or skips.
- Overrun:
  - Stimulus: second frame_start mid-scan.
  - Response: the scan continues unaffected, overrun=1 stays set, and only one frame_done is produced.
- Reset mid-frame:
  - Stimulus: drive reset=0 during WAIT.
  - Response: the next edge gives out_valid=0, busy=0, drop_count=0, overrun=0; a following frame_start rescans from node 0.
- Rounding:
  - Stimulus: x=0x000C8800.
  - Response: out_x=200 without PLOT_ROUND_EN, out_x=201 with it; x=0x000C87FF gives 200 in both builds.
